// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared constants and helpers for the registered binary-to-
//               one-hot decoder. Provides the default select width, the
//               output-width derivation (2**w) and the all-inactive output
//               pattern for either polarity.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    // Reference build select width.
    localparam int DEFAULT_IN_W = 3;

    // Widest supported output; the inactive helper is built at this width
    // and sliced down by the user.
    localparam int MAX_OUT_W = 64;

    // Output width is fully determined by the select width.
    function automatic int out_width(input int w);
        return 1 << w;
    endfunction

    // Pattern driven when nothing is selected: all zeros for active-high
    // outputs, all ones for active-low outputs.
    function automatic logic [MAX_OUT_W-1:0] all_inactive(input int active_low);
        return (active_low != 0) ? {MAX_OUT_W{1'b1}} : {MAX_OUT_W{1'b0}};
    endfunction

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_onehot.sv
`default_nettype none
// ============================================================================
// Module      : decoder_onehot
// Description : Purely combinational binary-to-one-hot decoder. Bit k of the
//               output is set exactly when the select equals k.
// Ports       : sel    [IN_W-1:0]  in  - binary select, MSB first
//               onehot [OUT_W-1:0] out - one-hot decode of sel
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEFAULT_IN_W,
    parameter int OUT_W = out_width(IN_W)
) (
    input  logic [IN_W-1:0]  sel,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < OUT_W; k++) begin
            onehot[k] = (sel == IN_W'(k));
        end
    end

endmodule : decoder_onehot
`default_nettype wire

// File: rtl/decoder_3to8.sv
`default_nettype none
// ============================================================================
// Module      : decoder_3to8
// Description : Registered binary-to-one-hot select decoder. The select is
//               decoded combinationally, optionally inverted for active-low
//               fan-out, and registered together with a valid strobe. When
//               en is low the output returns to the all-inactive pattern
//               (the previous decode is deliberately not held).
// Ports       : clk           in  - rising-edge clock
//               rst           in  - asynchronous active-high reset
//               en            in  - decode enable, sampled on clk
//               I [IN_W-1:0]  in  - binary select, I[IN_W-1] is the MSB
//               O [OUT_W-1:0] out - registered one-hot (or one-cold) decode
//               valid         out - high when O holds a decode of a sampled I
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_3to8
    import decoder_pkg::*;
#(
    parameter int IN_W       = DEFAULT_IN_W,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [IN_W-1:0]           I,
    output logic [out_width(IN_W)-1:0] O,
    output logic                      valid
);

    localparam int OUT_W = out_width(IN_W);

    localparam logic [MAX_OUT_W-1:0] INACTIVE_FULL = all_inactive(ACTIVE_LOW);
    localparam logic [OUT_W-1:0]     INACTIVE      = INACTIVE_FULL[OUT_W-1:0];

    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;
    logic             valid_d;
    logic             valid_q;

    decoder_onehot #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_onehot (
        .sel    (I),
        .onehot (onehot)
    );

    // Next-state: a disabled cycle forces the idle pattern so that
    // downstream selects never see a stale decode.
    always_comb begin
        out_d   = INACTIVE;
        valid_d = 1'b0;
        if (en) begin
            out_d   = (ACTIVE_LOW != 0) ? ~onehot : onehot;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= INACTIVE;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign O     = out_q;
    assign valid = valid_q;

    // Active bits are found by XOR with the idle pattern, which makes both
    // checks polarity-independent.
    a_onehot_or_idle : assert property (
        @(posedge clk) disable iff (rst) $onehot0(out_q ^ INACTIVE)
    );

    a_valid_consistent : assert property (
        @(posedge clk) disable iff (rst) (valid_q == (out_q != INACTIVE))
    );

endmodule : decoder_3to8
`default_nettype wire

// File: tb/tb_decoder_3to8.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_3to8
// Description : Self-checking bench for decoder_3to8. Runs an active-high
//               and an active-low instance side by side on shared stimulus
//               and compares both against an arithmetic reference model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_3to8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] I;
    logic [7:0] o_hi;
    logic       valid_hi;
    logic [7:0] o_lo;
    logic       valid_lo;

    int n_checks;
    int n_fail;

    decoder_3to8 #(.IN_W(3), .ACTIVE_LOW(0)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .I     (I),
        .O     (o_hi),
        .valid (valid_hi)
    );

    decoder_3to8 #(.IN_W(3), .ACTIVE_LOW(1)) dut_al (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .I     (I),
        .O     (o_lo),
        .valid (valid_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs expected while reset is held or just asserted.
    task automatic check_cleared(input string tag);
        check_eq({tag, "_o"},       o_hi,             8'h00);
        check_eq({tag, "_valid"},   {7'd0, valid_hi}, 8'h00);
        check_eq({tag, "_o_al"},    o_lo,             8'hFF);
        check_eq({tag, "_valid_al"},{7'd0, valid_lo}, 8'h00);
    endtask

    // Apply one cycle of stimulus and check the registered result against
    // the model: selected line = 2**sel when enabled, nothing otherwise.
    task automatic step(input string tag, input logic e, input logic [2:0] s);
        logic [7:0] exp_hi;
        en = e;
        I  = s;
        if (e && $isunknown(s)) begin
            n_fail++;
            $display("FAIL %s_sel_unknown: got %b expected known select", tag, s);
        end
        exp_hi = e ? 8'(1 << s) : 8'h00;
        @(posedge clk);
        #1;
        check_eq({tag, "_o"},        o_hi,             exp_hi);
        check_eq({tag, "_valid"},    {7'd0, valid_hi}, {7'd0, e});
        check_eq({tag, "_o_al"},     o_lo,             ~exp_hi);
        check_eq({tag, "_valid_al"}, {7'd0, valid_lo}, {7'd0, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        en  = 1'b1;
        I   = 3'b101;
        #1;
        check_cleared("reset_initial");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_cleared("reset_hold");
        end
        rst = 1'b0;

        // Full sweep, one decode per clock.
        for (int k = 0; k < 8; k++) begin
            step("sweep", 1'b1, 3'(k));
        end

        // Enable gating: decode, drop to idle, decode again.
        step("gate_on",  1'b1, 3'b011);
        step("gate_off", 1'b0, 3'b011);
        step("gate_re",  1'b1, 3'b011);

        // Mid-operation reset between clock edges.
        step("pre_rst", 1'b1, 3'b100);
        step("pre_rst", 1'b1, 3'b101);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("rst_async");
        I  = 3'b110;
        en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_cleared("rst_mid_hold");
        end
        #2;
        rst = 1'b0;
        step("post_rst", 1'b1, 3'b110);

        // Polarity-specific spot checks (both instances checked in step).
        step("pol", 1'b1, 3'b010);
        step("pol", 1'b0, 3'b010);

        // Random I/en against the model.
        for (int n = 0; n < 1000; n++) begin
            step("rand", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_decoder_3to8
`default_nettype wire

// File: doc/decoder_3to8.md
# decoder_3to8

Registered 3-to-8 line decoder: a 3-bit binary select `I` becomes a one-hot 8-bit word `O`, with bit `O[I]` active and all other bits inactive. It is the address/select decode stage feeding downstream enable and chip-select fan-out. Output is registered on the clock, qualified by an enable, and flagged with a `valid` strobe.

## Interface
- `IN_W`, default 3: select width. The reference build uses 3. Any value from 1 to 6 must elaborate.
- `OUT_W`, fixed at 2**IN_W (8): output width. Derived; not user-overridable.
- `ACTIVE_LOW`, default 0: when 1, the active output bit is 0 and inactive bits are 1.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: decode enable, sampled on `clk`.
- `I` input IN_W (3): binary select, `I[2]` is the MSB.
- `O` output OUT_W (8): registered one-hot decode. `O[k]` corresponds to `I == k`.
- `valid` output 1: high when `O` holds a decode of a sampled `I`.

## Operation
- Combinational decode: `onehot[k] = (I == k)` for k = 0..7. Exactly one bit is set for every known `I`.
- Rising `clk` with `en=1`: `O <= onehot` (bitwise inverted if `ACTIVE_LOW`), and `valid <= 1`.
- Rising `clk` with `en=0`: `O <=` all-inactive (0x00, or 0xFF if `ACTIVE_LOW`), and `valid <= 0`. The last decode is not held.
- While `rst=1`, or immediately on its assertion edge independent of `clk`: `O =` all-inactive and `valid = 0`.
- First rising `clk` after `rst` deasserts resumes normal operation.
- `O` is never multi-hot.
- `O` is all-inactive exactly when `valid=0`. This is an invariant and must be assertable.
- Mapping with `ACTIVE_LOW=0`:
  - I=000 → O=00000001
  - I=001 → 00000010
  - I=010 → 00000100
  - I=011 → 00001000
  - I=100 → 00010000
  - I=101 → 00100000
  - I=110 → 01000000
  - I=111 → 10000000
- Unknown bits (X/Z) on `I` while `en=1`: the bench flags this as an error. The RTL is not required to produce a defined value.

## Timing
- Latency: 1 clock. `I`/`en` sampled at edge n appear on `O`/`valid` after edge n.
- Throughput: one decode per clock. Back-to-back changes of `I` are each reflected on consecutive cycles.
- Reset assertion mid-operation clears outputs asynchronously, within the same cycle, without waiting for `clk`.
- Reset deassertion is synchronous to the design's use. Upstream guarantees release away from the `clk` edge.
- `en` and `I` changing on the same edge: both are sampled together, with no priority issue.
- No combinational path from inputs to outputs.

## Structure
- Package `decoder_pkg`: default `IN_W` constant, the `OUT_W` derivation function (2**w), and the all-inactive constant helper.
- Sub-module `decoder_onehot`: a purely combinational `IN_W`→`OUT_W` one-hot decoder (a for-loop compare).
- Top `decoder_3to8` contains:
  - the `decoder_onehot` instance,
  - the polarity inversion,
  - the output/valid register with async reset,
  - optional embedded assertions: one-hot or all-inactive, and the `valid` ↔ non-zero consistency.

## Test plan
- Reset: assert `rst` with `I=101`, `en=1` → `O=00000000` and `valid=0` immediately, with no `clk` edge required. Hold for 3 clocks and outputs stay cleared.
- Full sweep: `en=1`, drive `I` = 0..7 on consecutive clocks → one cycle later `O` = 00000001, 00000010, …, 10000000 in order, `valid=1` throughout.
- Enable gating: `I=011`, `en=1` for 1 clock, then `en=0` → `O=00001000`, `valid=1`, then next cycle `O=00000000`, `valid=0`. Re-assert `en` → `O=00001000` again.
- Mid-operation reset: sweeping with `en=1`, pulse `rst` between clock edges while `O=00100000` → `O` clears at the pulse. First edge after release with `I=110` → `O=01000000`.
- Polarity: `ACTIVE_LOW=1`, `I=010`, `en=1` → `O=11111011`. `en=0` → `O=11111111`, `valid=0`.
- Random: 1000 cycles of random `I`/`en` against a model → `O` equals the predicted one-hot or all-inactive every cycle, and the invariants never fire.
